// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl
// Transmit-side buffer in front of a UART byte engine. Producers push bytes into a
// DEPTH-entry FIFO. A small FSM pops one byte at a time and launches it through a
// start flag. It then waits for the UART to go busy and to become idle again.
//
// Handshake with the UART, level based:
//   UART_RDY=1 means the UART is idle. UART_START_FLAG is raised with UART_DIN already
//   valid. The flag is held until UART_RDY drops, which means the UART accepted the
//   byte. The next byte is not offered until UART_RDY returns high.
//
// Optional feature: define UART_TXFIFO_OVF_EN to add a sticky overflow flag
// (OVF_FLAG) with a synchronous clear input (OVF_CLR).

module uart_tx_fifo_ctrl #(
  parameter int BITWIDTH = 8,
  parameter int DEPTH    = 16
) (
  input  logic                     CLK_SYS,
  input  logic                     RST,
  input  logic                     FIFO_WR_EN,
  input  logic [BITWIDTH-1:0]      FIFO_DIN,
  output logic                     FIFO_FULL,
  output logic                     FIFO_EMPTY,
  output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
  input  logic                     UART_RDY,
  output logic                     UART_START_FLAG,
  output logic [BITWIDTH-1:0]      UART_DIN,
`ifdef UART_TXFIFO_OVF_EN
  input  logic                     OVF_CLR,
  output logic                     OVF_FLAG,
`endif
  output logic                     TX_BUSY
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t              state;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr_nxt;
  logic [PTR_W-1:0]    rd_ptr_nxt;
  logic [BITWIDTH-1:0] mem [DEPTH];
  logic                do_write;
  logic                do_pop;

  // A write is accepted only against the registered full flag. A pop in the same
  // cycle never frees room for it, so there is no pass-through.
  assign do_write   = FIFO_WR_EN && !FIFO_FULL;
  // The only pop point is S_LOAD. It is entered only when the FIFO is not empty.
  assign do_pop     = (state == S_LOAD);
  assign wr_ptr_nxt = do_write ? wr_ptr + PTR_W'(1) : wr_ptr;
  assign rd_ptr_nxt = do_pop   ? rd_ptr + PTR_W'(1) : rd_ptr;

  // Storage array, deliberately not reset.
  always_ff @(posedge CLK_SYS) begin
    if (do_write) begin
      mem[wr_ptr[ADDR_W-1:0]] <= FIFO_DIN;
    end
  end

  // Pointers plus status. Status is registered from the next pointer values, so it
  // reflects a write or pop from the cycle right after it.
  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_EMPTY <= 1'b1;
      FIFO_FULL  <= 1'b0;
      FIFO_LEVEL <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      FIFO_EMPTY <= (wr_ptr_nxt == rd_ptr_nxt);
      FIFO_FULL  <= (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]) &&
                    (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);
      FIFO_LEVEL <= wr_ptr_nxt - rd_ptr_nxt;
    end
  end

  // Launch FSM. All outputs are registered. UART_DIN changes only when leaving
  // S_LOAD, so the UART can sample it any time during its start bit.
  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      state           <= S_IDLE;
      UART_START_FLAG <= 1'b0;
      UART_DIN        <= '0;
      TX_BUSY         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!FIFO_EMPTY && UART_RDY) begin
            state   <= S_LOAD;
            TX_BUSY <= 1'b1;
          end
        end
        S_LOAD: begin
          UART_DIN        <= mem[rd_ptr[ADDR_W-1:0]];
          UART_START_FLAG <= 1'b1;
          state           <= S_START;
        end
        S_START: begin
          if (!UART_RDY) begin
            UART_START_FLAG <= 1'b0;
            state           <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (UART_RDY) begin
            state   <= S_IDLE;
            TX_BUSY <= 1'b0;
          end
        end
        default: begin
          state           <= S_IDLE;
          UART_START_FLAG <= 1'b0;
          TX_BUSY         <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TXFIFO_OVF_EN
  // Sticky overflow flag. A dropped write sets it. OVF_CLR clears it, but a
  // set in the same cycle takes priority over the clear.
  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      OVF_FLAG <= 1'b0;
    end else if (FIFO_WR_EN && FIFO_FULL) begin
      OVF_FLAG <= 1'b1;
    end else if (OVF_CLR) begin
      OVF_FLAG <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl. It includes a behavioural UART model:
// UART_RDY falls 2 cycles after the start flag is seen and stays low for 40 cycles.
// Inputs are driven and outputs sampled on the falling clock edge.
// Overflow checks are compiled in when UART_TXFIFO_OVF_EN is defined.

module tb_uart_tx_fifo_ctrl;

  logic       CLK_SYS;
  logic       RST;
  logic       FIFO_WR_EN;
  logic [7:0] FIFO_DIN;
  logic       FIFO_FULL;
  logic       FIFO_EMPTY;
  logic [4:0] FIFO_LEVEL;
  logic       UART_RDY;
  logic       UART_START_FLAG;
  logic [7:0] UART_DIN;
  logic       TX_BUSY;
`ifdef UART_TXFIFO_OVF_EN
  logic       OVF_CLR;
  logic       OVF_FLAG;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // UART model state
  logic       model_rdy = 1'b1;
  logic       force_low = 1'b0;
  int         phase     = 0;
  int         cnt       = 0;
  int         start_cnt = 0;
  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];

  assign UART_RDY = model_rdy && !force_low;

  uart_tx_fifo_ctrl #(.BITWIDTH(8), .DEPTH(16)) dut (
    .CLK_SYS         (CLK_SYS),
    .RST             (RST),
    .FIFO_WR_EN      (FIFO_WR_EN),
    .FIFO_DIN        (FIFO_DIN),
    .FIFO_FULL       (FIFO_FULL),
    .FIFO_EMPTY      (FIFO_EMPTY),
    .FIFO_LEVEL      (FIFO_LEVEL),
    .UART_RDY        (UART_RDY),
    .UART_START_FLAG (UART_START_FLAG),
    .UART_DIN        (UART_DIN),
`ifdef UART_TXFIFO_OVF_EN
    .OVF_CLR         (OVF_CLR),
    .OVF_FLAG        (OVF_FLAG),
`endif
    .TX_BUSY         (TX_BUSY)
  );

  // clock / reset
  initial CLK_SYS = 1'b0;
  always #5 CLK_SYS = ~CLK_SYS;

  // behavioural UART: capture byte on start flag, go busy 2 cycles later for 40 cycles
  always @(negedge CLK_SYS) begin
    case (phase)
      0: if (UART_START_FLAG) begin
           sent_q.push_back(UART_DIN);
           start_cnt = start_cnt + 1;
           cnt = 2;
           phase = 1;
         end
      1: begin
           cnt = cnt - 1;
           if (cnt == 0) begin
             model_rdy = 1'b0;
             cnt = 40;
             phase = 2;
           end
         end
      default: begin
           cnt = cnt - 1;
           if (cnt == 0) begin
             model_rdy = 1'b1;
             phase = 0;
           end
         end
    endcase
  end

  // driver tasks
  task automatic drive_write(input logic [7:0] b);
    @(negedge CLK_SYS);
    FIFO_WR_EN = 1'b1;
    FIFO_DIN   = b;
  endtask

  task automatic drive_idle();
    @(negedge CLK_SYS);
    FIFO_WR_EN = 1'b0;
    FIFO_DIN   = 8'h00;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK_SYS);
      if (FIFO_EMPTY && !TX_BUSY && phase == 0 && model_rdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sent(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK_SYS);
      if (sent_q.size() >= n && FIFO_EMPTY && !TX_BUSY) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK_SYS);
    n_checks++; if (FIFO_EMPTY !== 1'b1) $display("FAIL reset_empty got %b exp 1", FIFO_EMPTY); else n_pass++;
    n_checks++; if (FIFO_FULL !== 1'b0) $display("FAIL reset_full got %b exp 0", FIFO_FULL); else n_pass++;
    n_checks++; if (FIFO_LEVEL !== 5'd0) $display("FAIL reset_level got %0d exp 0", FIFO_LEVEL); else n_pass++;
    n_checks++; if (UART_START_FLAG !== 1'b0) $display("FAIL reset_flag got %b exp 0", UART_START_FLAG); else n_pass++;
    n_checks++; if (UART_DIN !== 8'h00) $display("FAIL reset_din got %h exp 00", UART_DIN); else n_pass++;
    n_checks++; if (TX_BUSY !== 1'b0) $display("FAIL reset_busy got %b exp 0", TX_BUSY); else n_pass++;
`ifdef UART_TXFIFO_OVF_EN
    n_checks++; if (OVF_FLAG !== 1'b0) $display("FAIL reset_ovf got %b exp 0", OVF_FLAG); else n_pass++;
`endif
    RST = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    wait_idle(ok);
    sent_q.delete(); exp_q.delete();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C); exp_q.push_back(8'hFF);
    drive_write(8'hA5);
    drive_write(8'h3C);
    drive_write(8'hFF);
    drive_idle();
    // three writes in, one popped by now; first byte launched
    n_checks++; if (FIFO_LEVEL !== 5'd2) $display("FAIL b2b_level got %0d exp 2", FIFO_LEVEL); else n_pass++;
    n_checks++; if (UART_START_FLAG !== 1'b1) $display("FAIL b2b_flag got %b exp 1", UART_START_FLAG); else n_pass++;
    n_checks++; if (UART_DIN !== 8'hA5) $display("FAIL b2b_din0 got %h exp a5", UART_DIN); else n_pass++;
    wait_sent(3, ok);
    n_checks++; if (!ok) $display("FAIL b2b_timeout got %0d bytes exp 3", sent_q.size()); else n_pass++;
    n_checks++; if (sent_q.size() != exp_q.size()) $display("FAIL b2b_count got %0d exp %0d", sent_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
      n_checks++; if (sent_q[i] !== exp_q[i]) $display("FAIL b2b_byte%0d got %h exp %h", i, sent_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (FIFO_LEVEL !== 5'd0) $display("FAIL b2b_level_end got %0d exp 0", FIFO_LEVEL); else n_pass++;
  endtask

  task automatic test_full();
    bit ok;
    wait_idle(ok);
    sent_q.delete(); exp_q.delete();
    force_low = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_write(8'(8'h40 + i));
      exp_q.push_back(8'(8'h40 + i));
    end
    drive_write(8'h77);
    n_checks++; if (FIFO_FULL !== 1'b1) $display("FAIL full_flag got %b exp 1", FIFO_FULL); else n_pass++;
    n_checks++; if (FIFO_LEVEL !== 5'd16) $display("FAIL full_level got %0d exp 16", FIFO_LEVEL); else n_pass++;
`ifdef UART_TXFIFO_OVF_EN
    n_checks++; if (OVF_FLAG !== 1'b0) $display("FAIL full_ovf_pre got %b exp 0", OVF_FLAG); else n_pass++;
`endif
    drive_idle();
    n_checks++; if (FIFO_LEVEL !== 5'd16) $display("FAIL full_drop_level got %0d exp 16", FIFO_LEVEL); else n_pass++;
`ifdef UART_TXFIFO_OVF_EN
    n_checks++; if (OVF_FLAG !== 1'b1) $display("FAIL full_ovf got %b exp 1", OVF_FLAG); else n_pass++;
`endif
    force_low = 1'b0;
    wait_sent(16, ok);
    n_checks++; if (!ok) $display("FAIL full_timeout got %0d bytes exp 16", sent_q.size()); else n_pass++;
    n_checks++; if (sent_q.size() != 16) $display("FAIL full_count got %0d exp 16", sent_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
      n_checks++; if (sent_q[i] !== exp_q[i]) $display("FAIL full_byte%0d got %h exp %h", i, sent_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_write_during_pop();
    bit ok;
    wait_idle(ok);
    sent_q.delete();
    drive_write(8'h22);
    drive_idle();
    n_checks++; if (FIFO_LEVEL !== 5'd1) $display("FAIL wdp_level_pre got %0d exp 1", FIFO_LEVEL); else n_pass++;
    drive_write(8'h11);          // sampled on the pop edge
    drive_idle();
    n_checks++; if (FIFO_LEVEL !== 5'd1) $display("FAIL wdp_level got %0d exp 1", FIFO_LEVEL); else n_pass++;
    n_checks++; if (UART_DIN !== 8'h22) $display("FAIL wdp_din got %h exp 22", UART_DIN); else n_pass++;
    wait_sent(2, ok);
    n_checks++; if (!ok || sent_q.size() != 2) $display("FAIL wdp_count got %0d exp 2", sent_q.size()); else n_pass++;
    n_checks++; if (sent_q.size() < 2 || sent_q[1] !== 8'h11) $display("FAIL wdp_second got %h exp 11", (sent_q.size() > 1) ? sent_q[1] : 8'hxx); else n_pass++;
  endtask

  task automatic test_rdy_hold();
    bit ok;
    int s0;
    wait_idle(ok);
    sent_q.delete();
    force_low = 1'b1;
    s0 = start_cnt;
    drive_write(8'h5A);
    drive_write(8'hC3);
    drive_idle();
    repeat (100) @(negedge CLK_SYS);
    n_checks++; if (start_cnt != s0) $display("FAIL hold_starts got %0d exp %0d", start_cnt, s0); else n_pass++;
    n_checks++; if (FIFO_LEVEL !== 5'd2) $display("FAIL hold_level got %0d exp 2", FIFO_LEVEL); else n_pass++;
    n_checks++; if (TX_BUSY !== 1'b0) $display("FAIL hold_busy got %b exp 0", TX_BUSY); else n_pass++;
    force_low = 1'b0;
    wait_sent(2, ok);
    n_checks++; if (!ok || sent_q.size() != 2 || sent_q[0] !== 8'h5A || sent_q[1] !== 8'hC3)
      $display("FAIL hold_bytes got %0d bytes exp 2 (5a c3)", sent_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int s0;
    wait_idle(ok);
    for (int i = 0; i < 6; i++) drive_write(8'(8'h90 + i));
    drive_idle();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (TX_BUSY && !UART_START_FLAG && !UART_RDY) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK_SYS);
    end
    n_checks++; if (!ok) $display("FAIL rstmid_wait_timeout got 0 exp 1"); else n_pass++;
    n_checks++; if (FIFO_LEVEL !== 5'd5) $display("FAIL rstmid_level_pre got %0d exp 5", FIFO_LEVEL); else n_pass++;
    RST = 1'b1;
    #1;
    n_checks++; if (FIFO_LEVEL !== 5'd0) $display("FAIL rstmid_level got %0d exp 0", FIFO_LEVEL); else n_pass++;
    n_checks++; if (FIFO_EMPTY !== 1'b1) $display("FAIL rstmid_empty got %b exp 1", FIFO_EMPTY); else n_pass++;
    n_checks++; if (TX_BUSY !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", TX_BUSY); else n_pass++;
    n_checks++; if (UART_DIN !== 8'h00) $display("FAIL rstmid_din got %h exp 00", UART_DIN); else n_pass++;
    @(negedge CLK_SYS);
    RST = 1'b0;
    s0 = start_cnt;
    repeat (200) @(negedge CLK_SYS);
    n_checks++; if (start_cnt != s0) $display("FAIL rstmid_starts got %0d exp %0d", start_cnt, s0); else n_pass++;
    n_checks++; if (FIFO_EMPTY !== 1'b1 || TX_BUSY !== 1'b0) $display("FAIL rstmid_after got empty=%b busy=%b exp 1 0", FIFO_EMPTY, TX_BUSY); else n_pass++;
  endtask

`ifdef UART_TXFIFO_OVF_EN
  task automatic test_ovf_clr();
    bit ok;
    wait_idle(ok);
    sent_q.delete();
    @(negedge CLK_SYS); OVF_CLR = 1'b1;
    @(negedge CLK_SYS); OVF_CLR = 1'b0;
    n_checks++; if (OVF_FLAG !== 1'b0) $display("FAIL ovf_preclr got %b exp 0", OVF_FLAG); else n_pass++;
    force_low = 1'b1;
    for (int i = 0; i < 16; i++) drive_write(8'(i));
    drive_write(8'h99);
    OVF_CLR = 1'b1;
    drive_idle();
    n_checks++; if (OVF_FLAG !== 1'b1) $display("FAIL ovf_set_wins got %b exp 1", OVF_FLAG); else n_pass++;
    @(negedge CLK_SYS); OVF_CLR = 1'b0;
    n_checks++; if (OVF_FLAG !== 1'b0) $display("FAIL ovf_clr got %b exp 0", OVF_FLAG); else n_pass++;
    force_low = 1'b0;
    wait_sent(16, ok);
    n_checks++; if (!ok || sent_q.size() != 16) $display("FAIL ovf_drain got %0d exp 16", sent_q.size()); else n_pass++;
  endtask
`endif

  initial begin
    RST        = 1'b1;
    FIFO_WR_EN = 1'b0;
    FIFO_DIN   = 8'h00;
`ifdef UART_TXFIFO_OVF_EN
    OVF_CLR    = 1'b0;
`endif
    test_reset();
    test_back_to_back();
    test_full();
    test_write_during_pop();
    test_rdy_hold();
    test_reset_mid();
`ifdef UART_TXFIFO_OVF_EN
    test_ovf_clr();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
